// File: rtl/wb_sequencer.sv
// Write-back sequencer for the multicycle MIPS datapath: holds the MemtoReg select
// stable until the chosen source is valid, then issues a single register-file write.
module wb_sequencer #(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic       clk,
    input  logic       reset,

    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_src,
    input  logic [4:0] req_rd,

    input  logic       mem_ready,
    input  logic       hilo_busy,
    input  logic       shift_done,

    output logic [3:0] mem_to_reg,
    output logic [4:0] wr_addr,
    output logic       reg_write,
    output logic       busy,
    output logic       err_timeout,
    output logic       err_code
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StWrite
    } state_t;

    localparam logic [3:0] SrcLoad  = 4'b0001;
    localparam logic [3:0] SrcHi    = 4'b0010;
    localparam logic [3:0] SrcLo    = 4'b0011;
    localparam logic [3:0] SrcShift = 4'b0100;
    localparam logic [3:0] SrcLast  = 4'b1000;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    logic accept;
    logic code_ok;
    logic src_ready;
    logic cnt_expired;

    // Readiness is judged on the captured select, not on the incoming request.
    always_comb begin
        src_ready = 1'b1;
        case (mem_to_reg)
            SrcLoad:      src_ready = mem_ready;
            SrcHi, SrcLo: src_ready = !hilo_busy;
            SrcShift:     src_ready = shift_done;
            default:      src_ready = 1'b1;
        endcase
    end

    assign req_ready   = (state != StWait);
    assign accept      = req_valid && req_ready;
    assign code_ok     = (req_src <= SrcLast);
    assign cnt_expired = (wait_cnt == CNT_W'(MAX_WAIT - 1));

    assign busy      = (state != StIdle);
    // $zero is never written; the WRITE cycle still completes normally.
    assign reg_write = (state == StWrite) && (wr_addr != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            wait_cnt    <= '0;
            mem_to_reg  <= 4'b0000;
            wr_addr     <= 5'd0;
            err_timeout <= 1'b0;
            err_code    <= 1'b0;
        end else begin
            err_timeout <= 1'b0;
            err_code    <= 1'b0;
            case (state)
                StIdle, StWrite: begin
                    if (accept && code_ok) begin
                        mem_to_reg <= req_src;
                        wr_addr    <= req_rd;
                        wait_cnt   <= '0;
                        state      <= StWait;
                    end else begin
                        err_code <= accept;
                        state    <= StIdle;
                    end
                end
                StWait: begin
                    if (src_ready) begin
                        state <= StWrite;
                    end else if (cnt_expired) begin
                        state       <= StIdle;
                        err_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/wb_sequencer.md
Name: wb_sequencer

Overview:
- Write-back controller for the multicycle MIPS datapath.
- Accepts one register write-back request per transaction: a source code plus a destination register.
- Drives the 4-bit MemtoReg select of the write-back mux and holds it stable while the chosen source (load data, Hi/Lo, shifter) becomes valid.
- Then pulses the register-file write enable for exactly one cycle, with a timeout that flags a source that never becomes valid.

Parameters:
- MAX_WAIT, 16: maximum number of cycles spent in WAIT before the transaction is abandoned (must be ≥1).
- CNT_W, 5: width of the wait counter (must satisfy 2^CNT_W > MAX_WAIT).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  write-back request present.
- req_ready  out  1  sequencer can accept a request this cycle.
- req_src  in  4  MemtoReg source code: 0000 AluOut, 0001 LoadSize, 0010 Hi, 0011 Lo, 0100 ShiftReg, 0101 constant, 0110 ShiftLeft16, 0111 B, 1000 SignExtend.
- req_rd  in  5  destination register number.
- mem_ready  in  1  load data valid (gates source 0001).
- hilo_busy  in  1  mult/div in progress (gates sources 0010 and 0011).
- shift_done  in  1  shifter result valid (gates source 0100).
- mem_to_reg  out  4  select to the write-back mux.
- wr_addr  out  5  register-file write address.
- reg_write  out  1  register-file write enable, one-cycle pulse.
- busy  out  1  transaction in flight (state ≠ IDLE).
- err_timeout  out  1  one-cycle pulse when a wait is abandoned.
- err_code  out  1  one-cycle pulse when a request with a code in 1001–1111 is accepted.

Behaviour:
- States: IDLE, WAIT, WRITE. The state register, mem_to_reg, wr_addr, the wait counter and both error flags are all registered.
- Reset value of every output:
  - mem_to_reg = 0000, wr_addr = 0, reg_write = 0, busy = 0, err_timeout = 0, err_code = 0.
  - Reset returns the state to IDLE and clears the counter, including mid-transaction.
  - A transaction interrupted by reset never produces reg_write.
- req_ready = 1 in IDLE and WRITE; 0 in WAIT. Handshake completes on a rising edge with req_valid && req_ready.
- Accept with a valid code (0000–1000):
  - On the accept edge, capture mem_to_reg ← req_src and wr_addr ← req_rd.
  - Clear the counter and enter WAIT.
- Accept with an invalid code (1001–1111):
  - Pulse err_code in the cycle after the accept edge.
  - Do not enter WAIT. Return to or stay in IDLE; mem_to_reg and wr_addr are unchanged.
- Source-ready rule:
  - 0001 requires mem_ready = 1.
  - 0010 and 0011 require hilo_busy = 0.
  - 0100 requires shift_done = 1.
  - All other valid codes are always ready.
- WAIT:
  - If the source is ready, go to WRITE.
  - Otherwise increment the counter. When the counter reaches MAX_WAIT−1 while still not ready, go to IDLE and pulse err_timeout in the following cycle; there is no reg_write.
- WRITE:
  - reg_write = 1 for this single cycle, except when wr_addr = 0: the transaction completes normally with reg_write held 0 ($zero is never written).
  - Next state is WAIT if a request is accepted this cycle (back-to-back), otherwise IDLE.
- Latency and throughput:
  - With the source ready immediately, reg_write is high in the 2nd cycle after the accept edge.
  - Back-to-back throughput is one write every 2 cycles.
- mem_to_reg and wr_addr:
  - Held constant from the accept edge through the end of WRITE.
  - Keep their last value in IDLE, so there are no select glitches between transactions.
- Simultaneous events:
  - Source ready on the same edge the counter would expire: ready wins and the write occurs.
  - reset together with req_valid: reset wins; the request is not accepted.

Test Plan:
- AluOut request: reset, then req_src=0000, req_rd=8 accepted at edge 0 → mem_to_reg=0000 from cycle 1; reg_write=1 with wr_addr=8 in cycle 2 only; busy=0 in cycle 3.
- Load stall: req_src=0001, mem_ready held 0 for 5 cycles then 1 → mem_to_reg stays 0001 throughout; exactly one reg_write pulse, on the cycle after mem_ready is first sampled high.
- Hi/Lo timeout: MAX_WAIT=4, req_src=0010 with hilo_busy stuck 1 → no reg_write; err_timeout pulses once; busy drops; req_ready returns to 1.
- $zero and invalid codes:
  - req_rd=0, req_src=0111 → no reg_write, transaction completes in 3 cycles.
  - req_src=1010 → err_code pulses once, state stays IDLE.
- Back-to-back: requests (0110, rd 3) then (1000, rd 4) held valid → reg_write pulses in cycles 2 and 4 with wr_addr 3 then 4; mem_to_reg switches to 1000 only after the first WRITE cycle.
- Reset mid-WAIT: req_src=0100, shift_done=0, reset asserted in cycle 2 → all outputs at reset values next cycle; no reg_write even if shift_done rises afterwards.
